// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the single MMIO bus, with a bus watchdog
// that completes stalled transfers with an error word and latches error status.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hdeadbeef
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        err_flag,
  output logic [31:0] err_addr,
  output logic        err_master,
  input  logic        err_clear
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 4;
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } bus_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_flag_q, err_flag_d;
  logic [AW-1:0]  err_addr_q, err_addr_d;
  logic           err_master_q, err_master_d;

  bus_req_t       own_req;
  logic           own_valid;
  logic           grant_ready;
  logic [DW-1:0]  grant_rdata;

  // Request of the current owner, forwarded to the slave while BUSY
  always_comb begin
    own_req   = owner_q ? bus_req_t'{m1_addr, m1_wdata, m1_wstrb}
                        : bus_req_t'{m0_addr, m0_wdata, m0_wstrb};
    own_valid = owner_q ? m1_valid : m0_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      wdog_q       <= '0;
      err_flag_q   <= 1'b0;
      err_addr_q   <= '0;
      err_master_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      wdog_q       <= wdog_d;
      err_flag_q   <= err_flag_d;
      err_addr_q   <= err_addr_d;
      err_master_q <= err_master_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    wdog_d       = wdog_q;
    err_flag_d   = err_flag_q;
    err_addr_d   = err_addr_q;
    err_master_d = err_master_q;
    s_valid      = 1'b0;
    s_addr       = '0;
    s_wdata      = '0;
    s_wstrb      = '0;
    grant_ready  = 1'b0;
    grant_rdata  = '0;

    if (err_clear) begin
      err_flag_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = ST_BUSY;
          wdog_d  = '0;
          // Tie goes to whichever master was not served last
          owner_d = (m0_valid && m1_valid) ? ~last_q : m1_valid;
        end
      end
      ST_BUSY: begin
        s_addr      = own_req.addr;
        s_wdata     = own_req.wdata;
        s_wstrb     = own_req.wstrb;
        grant_rdata = s_rdata;
        if (!own_valid) begin
          state_d = ST_IDLE;
          wdog_d  = '0;
        end else if (s_ready) begin
          s_valid     = 1'b1;
          grant_ready = 1'b1;
          last_d      = owner_q;
          wdog_d      = '0;
          state_d     = ST_IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          // Watchdog: withdraw the request and complete it with the error word
          grant_ready  = 1'b1;
          grant_rdata  = ERR_RDATA;
          err_flag_d   = 1'b1;
          err_addr_d   = own_req.addr;
          err_master_d = owner_q;
          last_d       = owner_q;
          wdog_d       = '0;
          state_d      = ST_IDLE;
        end else begin
          s_valid = 1'b1;
          wdog_d  = wdog_q + WDW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset cycle aborts the transfer with no completion visible to anyone
    if (rst) begin
      s_valid     = 1'b0;
      s_addr      = '0;
      s_wdata     = '0;
      s_wstrb     = '0;
      grant_ready = 1'b0;
      grant_rdata = '0;
    end
  end

  assign m0_ready   = grant_ready & ~owner_q;
  assign m1_ready   = grant_ready & owner_q;
  assign m0_rdata   = owner_q ? '0 : grant_rdata;
  assign m1_rdata   = owner_q ? grant_rdata : '0;
  assign err_flag   = err_flag_q;
  assign err_addr   = err_addr_q;
  assign err_master = err_master_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic, all
// cycles compared against a transaction-rule reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned TO   = 8;
  localparam logic [31:0] ERRW = 32'hdeadbeef;

  logic        clk = 1'b0;
  logic        rst;
  logic        mv[2];
  logic [31:0] ma[2];
  logic [31:0] mw[2];
  logic [3:0]  ms[2];
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        err_flag, err_master, err_clear;
  logic [31:0] err_addr;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRW)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(mv[0]), .m0_ready(m0_ready), .m0_addr(ma[0]), .m0_wdata(mw[0]),
    .m0_wstrb(ms[0]), .m0_rdata(m0_rdata),
    .m1_valid(mv[1]), .m1_ready(m1_ready), .m1_addr(ma[1]), .m1_wdata(mw[1]),
    .m1_wstrb(ms[1]), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .err_flag(err_flag), .err_addr(err_addr), .err_master(err_master),
    .err_clear(err_clear)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference model: is a transfer open, who holds it, how long it has waited
  bit          md_busy, md_owner, md_last, md_ef, md_em;
  int          md_age;
  logic [31:0] md_ea;

  // Slave behaviour: 0 always ready, 1 ready one cycle after request, 2 stuck,
  // 3 random, 4 driven by the test itself
  int          slv_mode = 0;
  int          sv_cnt   = 0;
  bit          rd_fixed_en = 0;
  logic [31:0] rd_fixed = '0;
  bit          last_rdy[2];

  // Observations of DUT behaviour, cleared per scenario
  int          tick_idx, obs_sv_cnt, obs_first_rdy, obs_both;
  int          obs_rdy_cnt[2];
  logic [31:0] obs_rd_cap[2];
  logic [31:0] obs_sa, obs_sw;
  logic [3:0]  obs_ss;
  bit          obs_order[$];

  task automatic clear_obs();
    tick_idx = 0; obs_sv_cnt = 0; obs_first_rdy = -1; obs_both = 0;
    obs_rdy_cnt[0] = 0; obs_rdy_cnt[1] = 0;
    obs_rd_cap[0] = '0; obs_rd_cap[1] = '0;
    obs_sa = '0; obs_sw = '0; obs_ss = '0;
    obs_order.delete();
  endtask

  task automatic model_reset();
    md_busy = 0; md_owner = 0; md_last = 1; md_age = 0;
    md_ef = 0; md_ea = '0; md_em = 0;
  endtask

  // One clock cycle: entered and left just after a rising edge
  task automatic tick();
    bit          e_sv, fire, done, o;
    bit          e_rdy[2];
    logic [31:0] e_rd[2];
    logic [31:0] e_sa, e_sw;
    logic [3:0]  e_ss;
    case (slv_mode)
      0: s_ready = 1'b1;
      1: s_ready = (sv_cnt >= 1);
      2: s_ready = 1'b0;
      3: s_ready = ($urandom_range(0, 3) == 0);
      default: ;
    endcase
    s_rdata = rd_fixed_en ? rd_fixed : $urandom();
    @(negedge clk);
    e_sv = 0; fire = 0; done = 0; o = md_owner;
    e_rdy[0] = 0; e_rdy[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
    e_sa = '0; e_sw = '0; e_ss = '0;
    if (!rst && md_busy) begin
      e_sa = ma[o]; e_sw = mw[o]; e_ss = ms[o]; e_rd[o] = s_rdata;
      if (mv[o]) begin
        if (s_ready) begin
          e_sv = 1; e_rdy[o] = 1; done = 1;
        end else if (md_age == int'(TO) - 1) begin
          fire = 1; e_rdy[o] = 1; e_rd[o] = ERRW;
        end else begin
          e_sv = 1;
        end
      end
    end
    chk("s_valid",    32'(s_valid),    32'(e_sv));
    chk("s_addr",     s_addr,          e_sa);
    chk("s_wdata",    s_wdata,         e_sw);
    chk("s_wstrb",    32'(s_wstrb),    32'(e_ss));
    chk("m0_ready",   32'(m0_ready),   32'(e_rdy[0]));
    chk("m1_ready",   32'(m1_ready),   32'(e_rdy[1]));
    chk("m0_rdata",   m0_rdata,        e_rd[0]);
    chk("m1_rdata",   m1_rdata,        e_rd[1]);
    chk("err_flag",   32'(err_flag),   32'(md_ef));
    chk("err_addr",   err_addr,        md_ea);
    chk("err_master", 32'(err_master), 32'(md_em));

    tick_idx++;
    if (s_valid) begin
      obs_sv_cnt++; obs_sa = s_addr; obs_sw = s_wdata; obs_ss = s_wstrb;
    end
    if (m0_ready && m1_ready) obs_both++;
    if (m0_ready) begin obs_rdy_cnt[0]++; obs_rd_cap[0] = m0_rdata; obs_order.push_back(1'b0); end
    if (m1_ready) begin obs_rdy_cnt[1]++; obs_rd_cap[1] = m1_rdata; obs_order.push_back(1'b1); end
    if ((m0_ready || m1_ready) && obs_first_rdy < 0) obs_first_rdy = tick_idx;

    last_rdy[0] = e_rdy[0]; last_rdy[1] = e_rdy[1];
    sv_cnt = (e_sv && !s_ready) ? sv_cnt + 1 : 0;

    if (rst) begin
      model_reset();
    end else begin
      if (err_clear) md_ef = 0;
      if (!md_busy) begin
        if (mv[0] || mv[1]) begin
          md_busy = 1; md_age = 0;
          md_owner = (mv[0] && mv[1]) ? !md_last : mv[1];
        end
      end else if (!mv[o]) begin
        md_busy = 0;
      end else if (done || fire) begin
        md_busy = 0; md_last = o;
        if (fire) begin md_ef = 1; md_ea = e_sa; md_em = o; end
      end else begin
        md_age++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mv[n] = 1'b1; ma[n] = a; mw[n] = d; ms[n] = s;
  endtask

  task automatic do_reset();
    mv[0] = 0; mv[1] = 0; err_clear = 0;
    rst = 1; tick(); rst = 0;
  endtask

  // Random masters: hold each request until completed, rarely abandon one
  task automatic rand_masters();
    for (int n = 0; n < 2; n++) begin
      if (!mv[n] || last_rdy[n]) begin
        if ($urandom_range(0, 2) == 0)
          req(n, {$urandom_range(0, 15), 4'h0, 8'h0, 12'($urandom()) & 12'hffc},
              $urandom(), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
        else
          mv[n] = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        mv[n] = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1; err_clear = 0; s_ready = 0; s_rdata = '0;
    for (int n = 0; n < 2; n++) begin mv[n] = 0; ma[n] = '0; mw[n] = '0; ms[n] = '0; end
    last_rdy[0] = 0; last_rdy[1] = 0;
    model_reset(); clear_obs();
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 0;
    chk("rst_err_flag",   32'(err_flag),   32'd0);
    chk("rst_err_addr",   err_addr,        32'd0);
    chk("rst_err_master", 32'(err_master), 32'd0);

    // m0 read, slave answers one cycle after the request
    slv_mode = 1; rd_fixed_en = 1; rd_fixed = 32'h12345678; clear_obs();
    req(0, 32'h100, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_rdy[0]) mv[0] = 0;
    end
    chk("t1_sv_cycles", 32'(obs_sv_cnt),     32'd2);
    chk("t1_m0_ready",  32'(obs_rdy_cnt[0]), 32'd1);
    chk("t1_m0_rdata",  obs_rd_cap[0],       32'h12345678);
    rd_fixed_en = 0;

    // Both masters requesting continuously against a zero-wait slave
    do_reset(); slv_mode = 0; clear_obs();
    req(0, 32'h200, 32'h1, 4'h0); req(1, 32'h300, 32'h2, 4'hf);
    repeat (16) tick();
    chk("t2_m0_cnt", 32'(obs_rdy_cnt[0]), 32'd4);
    chk("t2_m1_cnt", 32'(obs_rdy_cnt[1]), 32'd4);
    chk("t2_both",   32'(obs_both),       32'd0);
    for (int i = 0; i < 4; i++)
      chk("t2_order", (obs_order.size() > i) ? 32'(obs_order[i]) : 32'd2, 32'(i % 2));

    // m1 byte write while m0 is idle
    mv[0] = 0; mv[1] = 0; slv_mode = 1; tick(); tick(); clear_obs();
    req(1, 32'h10004, 32'hAA, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_rdy[1]) mv[1] = 0;
    end
    chk("t3_s_addr",   obs_sa,              32'h10004);
    chk("t3_s_wdata",  obs_sw,              32'hAA);
    chk("t3_s_wstrb",  32'(obs_ss),         32'd1);
    chk("t3_m1_ready", 32'(obs_rdy_cnt[1]), 32'd1);

    // Watchdog on a stuck slave, then err_clear coinciding with a second timeout
    do_reset(); slv_mode = 2; clear_obs();
    req(0, 32'h00050000, 32'h0, 4'h0);
    for (int i = 0; i < 20 && obs_rdy_cnt[0] == 0; i++) tick();
    mv[0] = 0;
    chk("t4_rdy_tick", 32'(obs_first_rdy), 32'd9);
    chk("t4_rdata",    obs_rd_cap[0],      ERRW);
    tick();
    chk("t4_err_flag",   32'(err_flag),   32'd1);
    chk("t4_err_addr",   err_addr,        32'h00050000);
    chk("t4_err_master", 32'(err_master), 32'd0);
    clear_obs();
    req(0, 32'h00060000, 32'h0, 4'h0);
    for (int i = 1; i <= 9; i++) begin
      err_clear = (i == 9);
      tick();
    end
    err_clear = 0; mv[0] = 0;
    chk("t4b_m0_ready", 32'(obs_rdy_cnt[0]), 32'd1);
    tick();
    chk("t4b_err_flag", 32'(err_flag), 32'd1);
    chk("t4b_err_addr", err_addr,      32'h00060000);
    err_clear = 1; tick(); err_clear = 0; tick();
    chk("t4c_err_flag", 32'(err_flag), 32'd0);

    // Slave answers on the last watchdog cycle: normal completion wins
    slv_mode = 4; s_ready = 0; rd_fixed_en = 1; rd_fixed = 32'h0badf00d; clear_obs();
    req(0, 32'h00070000, 32'h0, 4'h0);
    for (int i = 1; i <= 9; i++) begin
      s_ready = (i == 9);
      tick();
    end
    mv[0] = 0; s_ready = 0; rd_fixed_en = 0;
    tick();
    chk("t5_m0_ready", 32'(obs_rdy_cnt[0]), 32'd1);
    chk("t5_rdata",    obs_rd_cap[0],       32'h0badf00d);
    chk("t5_err_flag", 32'(err_flag),       32'd0);

    // Reset in the middle of an m1 transfer
    clear_obs();
    req(1, 32'h00080000, 32'h5, 4'h3);
    tick(); tick();
    rst = 1; s_ready = 1; tick();
    rst = 0; s_ready = 0;
    chk("t6_no_m1_ready", 32'(obs_rdy_cnt[1]), 32'd0);
    clear_obs();
    req(0, 32'h00090000, 32'h0, 4'h0);
    tick();
    chk("t6_s_valid_low", 32'(obs_sv_cnt), 32'd0);
    slv_mode = 0;
    tick(); tick();
    chk("t6_first_owner", (obs_order.size() > 0) ? 32'(obs_order[0]) : 32'd2, 32'd0);

    // Randomized traffic with varying slave behaviour, clears and resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 300 == 0) slv_mode = int'($urandom_range(0, 3));
      rand_masters();
      err_clear = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 0; err_clear = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
